user_stream_fifo: RTL and testbench

USER_STREAM_FIFO -- requirements
Module: user_stream_fifo

---
 rtl/user_stream_fifo_if.sv | 25 ++
 rtl/user_stream_fifo.sv | 67 ++++++
 tb/tb_user_stream_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/user_stream_fifo_if.sv
// Stream handshake bundle between a producer/consumer pair and user_stream_fifo.
// The FIFO takes the slave view; the environment driving it takes the master view.
interface user_stream_fifo_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    din_vld;
    logic                    din_ack;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    dout_vld;
    logic                    dout_ack;
    logic [DEPTH_BITS:0]     count;
    logic                    almost_full;

    modport slave (
        input  din, din_vld, dout_ack,
        output din_ack, dout, dout_vld, count, almost_full
    );

    modport master (
        output din, din_vld, dout_ack,
        input  din_ack, dout, dout_vld, count, almost_full
    );
endinterface

// File: rtl/user_stream_fifo.sv
// First-word fall-through FIFO between a leaf interface and a user kernel.
// Handshake outputs depend only on registered state (plus reset for din_ack).
module user_stream_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int AFULL_LEVEL  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    user_stream_fifo_if.slave    bus
);
    localparam int                  DEPTH   = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_C = DEPTH[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] AFULL_C = AFULL_LEVEL[DEPTH_BITS:0];

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]     count_q, count_d;
    logic                    push, pop;

    assign bus.din_ack     = !reset && (count_q < DEPTH_C);
    assign bus.dout_vld    = (count_q != '0);
    assign bus.dout        = mem_q[rd_ptr_q];
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= AFULL_C);

    // A pop on a full FIFO frees a slot only from the next cycle, since din_ack reads count_q.
    assign push = bus.din_vld && bus.din_ack;
    assign pop  = bus.dout_vld && bus.dout_ack && !reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end
endmodule

// File: tb/tb_user_stream_fifo.sv
// Bench for user_stream_fifo: fixed vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based model of the FIFO.
module tb_user_stream_fifo;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    user_stream_fifo_if #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) bus ();

    user_stream_fifo #(.PAYLOAD_BITS(32), .DEPTH_BITS(4), .AFULL_LEVEL(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] data;
        logic        ack;
        int          cnt;
        logic        dvld;
        logic        dack;
        logic        af;
        logic        chk_d;
        logic [31:0] dout;
    } vec_t;

    function automatic vec_t mk(logic rst, logic vld, logic [31:0] data, logic ack,
                                int cnt, logic dvld, logic dack, logic af,
                                logic chk_d, logic [31:0] dout);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.ack = ack;
        v.cnt = cnt; v.dvld = dvld; v.dack = dack; v.af = af;
        v.chk_d = chk_d; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic a);
        bit push, pop;
        reset       = r;
        bus.din     = d;
        bus.din_vld = v;
        bus.dout_ack = a;
        #1;
        chk("din_ack", 64'(bus.din_ack), 64'(!r && q.size() < 16));
        chk("dout_vld", 64'(bus.dout_vld), 64'(q.size() != 0));
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= 12));
        if (q.size() != 0) chk("dout", 64'(bus.dout), 64'(q[0]));
        push = !r && v && (q.size() < 16);
        pop  = !r && a && (q.size() != 0);
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        reset = 1'b1;
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.dout_ack = 1'b0;
        @(posedge clk);
        #1;

        // Basic push/hold/pop, empty-ack ignore, no bypass, idle din ignored.
        tbl[0]  = mk(1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 1, 32'h1,    0, 1, 1, 1, 0, 1, 32'h1);
        tbl[2]  = mk(0, 1, 32'h2,    0, 2, 1, 1, 0, 1, 32'h1);
        tbl[3]  = mk(0, 1, 32'h3,    0, 3, 1, 1, 0, 1, 32'h1);
        tbl[4]  = mk(0, 0, 32'h0,    0, 3, 1, 1, 0, 1, 32'h1);
        tbl[5]  = mk(0, 0, 32'h0,    1, 2, 1, 1, 0, 1, 32'h2);
        tbl[6]  = mk(0, 0, 32'h0,    1, 1, 1, 1, 0, 1, 32'h3);
        tbl[7]  = mk(0, 0, 32'h0,    1, 0, 0, 1, 0, 0, 32'h0);
        tbl[8]  = mk(0, 0, 32'h0,    1, 0, 0, 1, 0, 0, 32'h0);
        tbl[9]  = mk(0, 1, 32'hA5,   1, 1, 1, 1, 0, 1, 32'hA5);
        tbl[10] = mk(0, 0, 32'h0,    1, 0, 0, 1, 0, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'hDEAD, 0, 0, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].ack);
            chk("tbl_count", 64'(bus.count), 64'(tbl[i].cnt));
            chk("tbl_dout_vld", 64'(bus.dout_vld), 64'(tbl[i].dvld));
            chk("tbl_din_ack", 64'(bus.din_ack), 64'(tbl[i].dack));
            chk("tbl_almost_full", 64'(bus.almost_full), 64'(tbl[i].af));
            if (tbl[i].chk_d) chk("tbl_dout", 64'(bus.dout), 64'(tbl[i].dout));
        end

        // Fill to full, overflow attempt, simultaneous push/pop while full.
        cycle(1, 0, 32'h0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 32'h1000 + 32'(i), 0);
            if (i == 11) chk("af_at_12", 64'(bus.almost_full), 64'd1);
            if (i == 10) chk("af_at_11", 64'(bus.almost_full), 64'd0);
        end
        chk("full_count", 64'(bus.count), 64'd16);
        chk("full_din_ack", 64'(bus.din_ack), 64'd0);
        chk("full_af", 64'(bus.almost_full), 64'd1);
        cycle(0, 1, 32'hBAD, 0);
        chk("overflow_count", 64'(bus.count), 64'd16);
        chk("overflow_dout", 64'(bus.dout), 64'h1000);
        cycle(0, 1, 32'h2000, 1);
        chk("full_pushpop_count", 64'(bus.count), 64'd15);
        chk("full_pushpop_dout", 64'(bus.dout), 64'h1001);
        cycle(0, 1, 32'h2000, 0);
        chk("refill_count", 64'(bus.count), 64'd16);
        for (int i = 0; i < 16; i++) cycle(0, 0, 32'h0, 1);
        chk("drained_count", 64'(bus.count), 64'd0);

        // Continuous streaming through pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 32'h3000 + 32'(i), 1);
            chk("stream_count", 64'(bus.count), 64'd1);
            chk("stream_dout", 64'(bus.dout), 64'h3000 + 64'(i));
        end
        cycle(0, 0, 32'h0, 1);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h5000 + 32'(i), 0);
        chk("pre_reset_count", 64'(bus.count), 64'd5);
        cycle(1, 1, 32'h5555, 1);
        reset = 1'b0;
        bus.din_vld = 1'b0;
        bus.dout_ack = 1'b0;
        #1;
        chk("post_reset_count", 64'(bus.count), 64'd0);
        chk("post_reset_dout_vld", 64'(bus.dout_vld), 64'd0);
        chk("post_reset_af", 64'(bus.almost_full), 64'd0);
        chk("post_reset_din_ack", 64'(bus.din_ack), 64'd1);
        cycle(0, 1, 32'h77, 0);
        chk("post_reset_new_dout", 64'(bus.dout), 64'h77);
        cycle(0, 0, 32'h0, 1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (bus.count > 16) chk("count_range", 64'(bus.count), 64'd16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
